seq_fixed_mult: RTL and testbench



---
 rtl/seq_fixed_mult_if.sv | 32 +++
 rtl/seq_fixed_mult.sv | 148 ++++++++++++++
 tb/tb_seq_fixed_mult.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_fixed_mult_if.sv
// seq_fixed_mult_if: start/busy/done handshake and operand/result bus for
// the iterative signed fixed-point multiplier.
//   start  - request, sampled only while the multiplier is idle
//   a, b   - WIDTH-bit two's-complement operands
//   busy   - operation in progress
//   done   - one-cycle pulse, results valid
//   p      - full product rescaled by FRAC (2*WIDTH bits)
//   p_sat  - p saturated to WIDTH bits
//   ovf    - p did not fit WIDTH bits
// master: the requester; slave: the multiplier.
interface seq_fixed_mult_if #(
    parameter int WIDTH = 16
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     p;
    logic [WIDTH-1:0]       p_sat;
    logic                   ovf;

    modport master (
        output start, a, b,
        input  busy, done, p, p_sat, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, p, p_sat, ovf
    );
endinterface

// File: rtl/seq_fixed_mult.sv
// seq_fixed_mult: iterative signed fixed-point multiplier.
// Operands are Q(WIDTH-FRAC).FRAC two's complement. Magnitudes are multiplied
// with a radix-2 shift-add over WIDTH cycles; the sign is re-applied at the
// end, after the FRAC-bit rescale, so results truncate toward zero.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - seq_fixed_mult_if slave: start/a/b in, busy/done/p/p_sat/ovf out
module seq_fixed_mult #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 6
) (
    input  logic            clk,
    input  logic            rst,
    seq_fixed_mult_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    // Saturation thresholds on the product magnitude
    localparam logic [2*WIDTH-1:0] POS_LIMIT = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [2*WIDTH-1:0] NEG_LIMIT = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]   SAT_POS   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]   SAT_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 sign_q;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;

    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   p_q;
    logic [WIDTH-1:0]     p_sat_q;
    logic                 ovf_q;

    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   mag;
    logic [2*WIDTH-1:0]   p_next;
    logic [WIDTH-1:0]     p_sat_next;
    logic                 ovf_next;
    logic                 last_step;

    // |-2^(WIDTH-1)| wraps back to 2^(WIDTH-1), which is correct as unsigned
    assign abs_a     = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign abs_b     = bus.b[WIDTH-1] ? -bus.b : bus.b;
    assign addend    = {{WIDTH{1'b0}}, mag_a} << cnt;
    assign last_step = (cnt == CW'(WIDTH-1));

    // Rescale the magnitude before negating so the result rounds toward zero
    always_comb begin
        mag        = acc >> FRAC;
        p_next     = sign_q ? -mag : mag;
        p_sat_next = p_next[WIDTH-1:0];
        ovf_next   = 1'b0;
        if (!sign_q && (mag > POS_LIMIT)) begin
            p_sat_next = SAT_POS;
            ovf_next   = 1'b1;
        end else if (sign_q && (mag > NEG_LIMIT)) begin
            p_sat_next = SAT_NEG;
            ovf_next   = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (last_step) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_a   <= '0;
            mag_b   <= '0;
            sign_q  <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= '0;
            p_sat_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mag_a  <= abs_a;
                        mag_b  <= abs_b;
                        sign_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                CALC: begin
                    if (mag_b[0]) begin
                        acc <= acc + addend;
                    end
                    mag_b <= mag_b >> 1;
                    cnt   <= cnt + 1'b1;
                    // busy covers the WIDTH shift-add steps only
                    if (last_step) begin
                        busy_q <= 1'b0;
                    end
                end
                FINISH: begin
                    p_q     <= p_next;
                    p_sat_q <= p_sat_next;
                    ovf_q   <= ovf_next;
                    done_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.p     = p_q;
    assign bus.p_sat = p_sat_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_seq_fixed_mult.sv
// tb_seq_fixed_mult: scoreboard bench for seq_fixed_mult (WIDTH=16, FRAC=6).
// Expected results come from a behavioural model using a native signed
// multiply, truncation of the magnitude and explicit saturation.
module tb_seq_fixed_mult;

    localparam int WIDTH = 16;
    localparam int FRAC  = 6;

    typedef struct packed {
        logic [31:0] p;
        logic [15:0] p_sat;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_fixed_mult_if #(.WIDTH(WIDTH)) bus ();

    seq_fixed_mult #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t   r;
        longint pr;
        longint m;
        logic   s;
        pr = longint'($signed(a)) * longint'($signed(b));
        s  = a[15] ^ b[15];
        m  = (pr < 0) ? -pr : pr;
        m  = m >> FRAC;
        r.p = s ? 32'(-m) : 32'(m);
        if (!s && m > 32767) begin
            r.p_sat = 16'h7FFF;
            r.ovf   = 1'b1;
        end else if (s && m > 32768) begin
            r.p_sat = 16'h8000;
            r.ovf   = 1'b1;
        end else begin
            r.p_sat = r.p[15:0];
            r.ovf   = 1'b0;
        end
        return r;
    endfunction

    // Drive a one-cycle start at the current negedge and record the expectation
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        sb.push_back(model(a, b));
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
    endtask

    // n = negedges after the accepting edge until done is seen (bounded)
    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            if (bus.busy === 1'b1) bc++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.busy, bus.done, bus.p, bus.p_sat, bus.ovf} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b p=%h p_sat=%h ovf=%b, expected all 0",
                     bus.busy, bus.done, bus.p, bus.p_sat, bus.ovf);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int   n, bc;
        exp_t e;
        issue(16'h00C0, 16'h00A0);
        wait_done(n, bc);
        vectors++;
        if (n !== 17) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d, expected 17", n);
        end
        vectors++;
        if (bc !== 16) begin
            miscompares++;
            $display("FAIL basic_busy_cycles: got %0d, expected 16", bc);
        end
        vectors++;
        if (bus.p !== 32'h000001E0 || bus.p_sat !== 16'h01E0 || bus.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_const: got p=%h p_sat=%h ovf=%b, expected 000001e0 01e0 0",
                     bus.p, bus.p_sat, bus.ovf);
        end
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL basic_sb: got empty scoreboard, expected one entry");
        end else begin
            e = sb.pop_front();
            if ({bus.p, bus.p_sat, bus.ovf} !== e) begin
                miscompares++;
                $display("FAIL basic_result: got p=%h p_sat=%h ovf=%b, expected p=%h p_sat=%h ovf=%b",
                         bus.p, bus.p_sat, bus.ovf, e.p, e.p_sat, e.ovf);
            end
        end
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0 || bus.p !== 32'h000001E0) begin
            miscompares++;
            $display("FAIL done_pulse_hold: got done=%b p=%h, expected 0 000001e0", bus.done, bus.p);
        end
    endtask

    task automatic test_signs();
        logic [15:0] ta[6] = '{16'hFF40, 16'hFF40, 16'h0001, 16'h1234, 16'hC000, 16'h0000};
        logic [15:0] tb[6] = '{16'h00A0, 16'hFF60, 16'hFFFF, 16'hFEDC, 16'h0003, 16'h8000};
        int   n, bc;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            issue(ta[i], tb[i]);
            wait_done(n, bc);
            vectors++;
            if (n !== 17 || sb.size() == 0) begin
                miscompares++;
                $display("FAIL signs_%0d_done: got latency %0d, expected 17", i, n);
                sb.delete();
            end else begin
                e = sb.pop_front();
                if ({bus.p, bus.p_sat, bus.ovf} !== e) begin
                    miscompares++;
                    $display("FAIL signs_%0d: got p=%h p_sat=%h ovf=%b, expected p=%h p_sat=%h ovf=%b",
                             i, bus.p, bus.p_sat, bus.ovf, e.p, e.p_sat, e.ovf);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] ta[4] = '{16'h7FFF, 16'h8000, 16'h8000, 16'h0200};
        logic [15:0] tb[4] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'hF000};
        int   n, bc;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb[i]);
            wait_done(n, bc);
            vectors++;
            if (n !== 17 || sb.size() == 0) begin
                miscompares++;
                $display("FAIL ovf_%0d_done: got latency %0d, expected 17", i, n);
                sb.delete();
            end else begin
                e = sb.pop_front();
                if ({bus.p, bus.p_sat, bus.ovf} !== e) begin
                    miscompares++;
                    $display("FAIL ovf_%0d: got p=%h p_sat=%h ovf=%b, expected p=%h p_sat=%h ovf=%b",
                             i, bus.p, bus.p_sat, bus.ovf, e.p, e.p_sat, e.ovf);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        int   n, bc, extra;
        exp_t e;
        issue(16'h0140, 16'hFE80);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h7FFF;
        bus.b     = 16'h7FFF;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n, bc);
        vectors++;
        if (n + 6 !== 17) begin
            miscompares++;
            $display("FAIL ignore_latency: got %0d, expected 17", n + 6);
        end
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL ignore_sb: got empty scoreboard, expected one entry");
        end else begin
            e = sb.pop_front();
            if ({bus.p, bus.p_sat, bus.ovf} !== e) begin
                miscompares++;
                $display("FAIL ignore_result: got p=%h p_sat=%h ovf=%b, expected p=%h p_sat=%h ovf=%b",
                         bus.p, bus.p_sat, bus.ovf, e.p, e.p_sat, e.ovf);
            end
        end
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL ignore_no_second_done: got %0d extra done pulses, expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int   n, bc;
        exp_t e;
        issue(16'h0280, 16'h0050);
        wait_done(n, bc);
        vectors++;
        if (n !== 17 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL b2b_first_done: got latency %0d, expected 17", n);
            sb.delete();
        end else begin
            e = sb.pop_front();
            if ({bus.p, bus.p_sat, bus.ovf} !== e) begin
                miscompares++;
                $display("FAIL b2b_first: got p=%h p_sat=%h ovf=%b, expected p=%h p_sat=%h ovf=%b",
                         bus.p, bus.p_sat, bus.ovf, e.p, e.p_sat, e.ovf);
            end
        end
        // start raised while done is high
        issue(16'hFD00, 16'h0123);
        wait_done(n, bc);
        vectors++;
        if (n + 1 !== 18) begin
            miscompares++;
            $display("FAIL b2b_gap: got %0d cycles between done pulses, expected 18", n + 1);
        end
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL b2b_sb: got empty scoreboard, expected one entry");
        end else begin
            e = sb.pop_front();
            if ({bus.p, bus.p_sat, bus.ovf} !== e) begin
                miscompares++;
                $display("FAIL b2b_second: got p=%h p_sat=%h ovf=%b, expected p=%h p_sat=%h ovf=%b",
                         bus.p, bus.p_sat, bus.ovf, e.p, e.p_sat, e.ovf);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int   n, bc, dones;
        exp_t e;
        issue(16'h0333, 16'h0444);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.busy, bus.done, bus.p, bus.p_sat, bus.ovf} !== '0) begin
            miscompares++;
            $display("FAIL reset_async: got busy=%b done=%b p=%h p_sat=%h ovf=%b, expected all 0",
                     bus.busy, bus.done, bus.p, bus.p_sat, bus.ovf);
        end
        sb.delete();
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL reset_no_done: got %0d done pulses, expected 0", dones);
        end
        issue(16'h0040, 16'h0040);
        wait_done(n, bc);
        vectors++;
        if (n !== 17 || bus.p !== 32'h00000040) begin
            miscompares++;
            $display("FAIL reset_restart: got latency %0d p=%h, expected 17 00000040", n, bus.p);
        end
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL reset_sb: got empty scoreboard, expected one entry");
        end else begin
            e = sb.pop_front();
            if ({bus.p, bus.p_sat, bus.ovf} !== e) begin
                miscompares++;
                $display("FAIL reset_restart_result: got p=%h p_sat=%h ovf=%b, expected p=%h p_sat=%h ovf=%b",
                         bus.p, bus.p_sat, bus.ovf, e.p, e.p_sat, e.ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
